// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: segment constants,
// scan state encoding, the scan state record and timing helpers.
package fnd_pkg;

  // All segments dark (active-low drive).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Per-slot phase: dark guard interval, then the digit is driven.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Scan state kept as one record so checkers can bind to a single signal.
  // idx is 3 bits because at most 8 digits are supported.
  typedef struct packed {
    scan_state_t state;
    logic [2:0]  idx;
    logic        pending;
  } scan_dbg_t;

  // Clocks per digit slot.
  function automatic int calc_div(input int clk_hz, input int slot_hz);
    return clk_hz / slot_hz;
  endfunction

  // Width of a counter that counts 0..div-1.
  function automatic int calc_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_hex7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order gfedcba.
module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Plain lookup table; b and d are the lower-case glyphs.
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// A prescaler emits a one-cycle tick every DIV clocks; each tick starts a
// new digit slot which is dark for BLANK_CYC clocks (anti-ghosting) and
// then drives the selected digit until the next tick.
//
// Load handshake: load=1 on any clock captures value_in/dp_in into a
// pending buffer. The pending buffer is copied to the displayed buffer only
// on the wrap tick (last digit -> digit 0), so a frame never mixes old and
// new data. load_ack pulses for one clock, together with frame_start, when
// the new data becomes active. A load coinciding with the wrap tick is
// committed straight from the inputs. There is no back-pressure: load is
// always accepted and a newer load simply replaces an uncommitted one.
//
// All outputs are registered; they are computed from next-state values so
// that they line up with the state register in the same clock.
// Intended ranges: DIV >= 4, 2 <= DIGITS <= 8, 1 <= BLANK_CYC < DIV.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ    = 25000000,
  parameter int SLOT_HZ   = 1000,
  parameter int DIGITS    = 4,
  parameter int BLANK_CYC = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  load_ack,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int DIV = calc_div(CLK_HZ, SLOT_HZ);
  localparam int CW  = calc_cnt_w(DIV);
  localparam logic [CW-1:0] LAST_CNT   = CW'(DIV - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYC - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(DIGITS - 1);

  logic [CW-1:0]         pre_cnt, pre_cnt_n;
  logic [CW-1:0]         blank_cnt, blank_cnt_n;
  scan_dbg_t             st, st_n;
  logic [4*DIGITS-1:0]   active_val, active_val_n;
  logic [DIGITS-1:0]     active_dp, active_dp_n;
  logic [4*DIGITS-1:0]   pend_val, pend_val_n;
  logic [DIGITS-1:0]     pend_dp, pend_dp_n;

  logic                  tick, wrap;
  logic                  ack_n;
  logic [DIGITS-1:0]     an_n;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [DIGITS-1:0]     zero_from;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_zero;
  logic                  suppress;
  logic [6:0]            dec_seg;

  assign tick = (pre_cnt == LAST_CNT);
  assign wrap = tick && (st.idx == LAST_IDX);

  // Next prescaler count, slot sequencing and buffer commit.
  always_comb begin
    pre_cnt_n    = tick ? '0 : pre_cnt + 1'b1;
    st_n         = st;
    blank_cnt_n  = blank_cnt;
    active_val_n = active_val;
    active_dp_n  = active_dp;
    pend_val_n   = pend_val;
    pend_dp_n    = pend_dp;
    ack_n        = 1'b0;

    if (tick) begin
      st_n.state  = BLANK;
      st_n.idx    = wrap ? 3'd0 : st.idx + 3'd1;
      blank_cnt_n = '0;
    end else if (st.state == BLANK) begin
      if (blank_cnt == LAST_BLANK) begin
        st_n.state = DRIVE;
      end else begin
        blank_cnt_n = blank_cnt + 1'b1;
      end
    end

    if (wrap) begin
      if (load) begin
        active_val_n = value_in;
        active_dp_n  = dp_in;
        st_n.pending = 1'b0;
        ack_n        = 1'b1;
      end else if (st.pending) begin
        active_val_n = pend_val;
        active_dp_n  = pend_dp;
        st_n.pending = 1'b0;
        ack_n        = 1'b1;
      end
    end else if (load) begin
      pend_val_n   = value_in;
      pend_dp_n    = dp_in;
      st_n.pending = 1'b1;
    end
  end

  // Select the digit to show next and work out leading-zero suppression:
  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
  always_comb begin
    zero_run = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (active_val_n[4*i +: 4] == 4'h0);
      zero_from[i] = zero_run;
    end

    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (st_n.idx == 3'(i)) begin
        cur_nib  = active_val_n[4*i +: 4];
        cur_dp   = active_dp_n[i];
        cur_zero = zero_from[i];
      end
    end
    suppress = lz_en && (st_n.idx != 3'd0) && cur_zero;
  end

  hex7seg u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  // Pin values for the next clock: dark in BLANK, one anode low in DRIVE.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      an_n[i] = !((st_n.state == DRIVE) && (st_n.idx == 3'(i)));
    end
    if (st_n.state == DRIVE) begin
      seg_n = suppress ? SEG_OFF : dec_seg;
      dp_n  = ~cur_dp;
    end else begin
      seg_n = SEG_OFF;
      dp_n  = 1'b1;
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      blank_cnt   <= '0;
      st          <= '{state: BLANK, idx: 3'd0, pending: 1'b0};
      active_val  <= '0;
      active_dp   <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt     <= pre_cnt_n;
      blank_cnt   <= blank_cnt_n;
      st          <= st_n;
      active_val  <= active_val_n;
      active_dp   <= active_dp_n;
      pend_val    <= pend_val_n;
      pend_dp     <= pend_dp_n;
      an          <= an_n;
      seg         <= seg_n;
      dp          <= dp_n;
      load_ack    <= ack_n;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with DIV=10, BLANK_CYC=2, DIGITS=4.
// Cycle 0 is the first clock after reset release; a frame is 40 clocks,
// digit d of frame f occupies cycles 40f+10d .. 40f+10d+9 and is driven
// from 40f+10d+2. Wrap ticks occur at cycle 40f+39, so ack/frame_start
// are seen at cycle 40f.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  fnd_scan_ctrl #(
    .CLK_HZ    (100),
    .SLOT_HZ   (10),
    .DIGITS    (4),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .load_ack    (load_ack),
    .lz_en       (lz_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // Clock.
  always #5 clk = ~clk;

  // One record: inputs held during cycle at-1, outputs expected at cycle at.
  typedef struct {
    int         at;
    logic [15:0] val;
    logic [3:0]  dpv;
    logic        ld;
    logic        lz;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ack;
    logic        e_fs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int at, input logic [15:0] val, input logic [3:0] dpv,
                     input logic ld, input logic lz, input logic [3:0] e_an,
                     input logic [6:0] e_seg, input logic e_dp,
                     input logic e_ack, input logic e_fs);
    vec_t v;
    v.at = at; v.val = val; v.dpv = dpv; v.ld = ld; v.lz = lz;
    v.e_an = e_an; v.e_seg = e_seg; v.e_dp = e_dp; v.e_ack = e_ack; v.e_fs = e_fs;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp, input logic e_ack, input logic e_fs);
    chk({tag, ".an"},          16'(an),          16'(e_an));
    chk({tag, ".seg"},         16'(seg),         16'(e_seg));
    chk({tag, ".dp"},          16'(dp),          16'(e_dp));
    chk({tag, ".load_ack"},    16'(load_ack),    16'(e_ack));
    chk({tag, ".frame_start"}, 16'(frame_start), 16'(e_fs));
  endtask

  initial begin
    rst      = 1'b1;
    value_in = 16'h0000;
    dp_in    = 4'h0;
    load     = 1'b0;
    lz_en    = 1'b0;

    //            at   val      dp   ld lz  an     seg    dp ack fs
    // Reset exit and first slots with an all-zero active buffer.
    add(1,   16'h0000, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 0, 0);
    add(2,   16'h0000, 4'h0, 0, 0, 4'hE, 7'h40, 1, 0, 0);
    add(9,   16'h0000, 4'h0, 0, 0, 4'hE, 7'h40, 1, 0, 0);
    add(10,  16'h0000, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 0, 0);
    add(11,  16'h0000, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 0, 0);
    add(12,  16'h0000, 4'h0, 0, 0, 4'hD, 7'h40, 1, 0, 0);
    add(25,  16'h0000, 4'h0, 0, 0, 4'hB, 7'h40, 1, 0, 0);
    add(40,  16'h0000, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 0, 1);
    // Mid-frame load of 0x1234: held back until the wrap.
    add(50,  16'h1234, 4'h0, 1, 0, 4'hF, 7'h7F, 1, 0, 0);
    add(52,  16'h1234, 4'h0, 0, 0, 4'hD, 7'h40, 1, 0, 0);
    add(75,  16'h1234, 4'h0, 0, 0, 4'h7, 7'h40, 1, 0, 0);
    add(80,  16'h1234, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 1, 1);
    add(82,  16'h1234, 4'h0, 0, 0, 4'hE, 7'h19, 1, 0, 0);
    add(92,  16'h1234, 4'h0, 0, 0, 4'hD, 7'h30, 1, 0, 0);
    add(102, 16'h1234, 4'h0, 0, 0, 4'hB, 7'h24, 1, 0, 0);
    add(112, 16'h1234, 4'h0, 0, 0, 4'h7, 7'h79, 1, 0, 0);
    // Two loads in one frame: last one wins, one ack.
    add(126, 16'h1111, 4'h0, 1, 0, 4'hE, 7'h19, 1, 0, 0);
    add(141, 16'hABCD, 4'h0, 1, 0, 4'hF, 7'h7F, 1, 0, 0);
    add(155, 16'hABCD, 4'h0, 0, 0, 4'h7, 7'h79, 1, 0, 0);
    add(160, 16'hABCD, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 1, 1);
    add(161, 16'hABCD, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 0, 0);
    add(162, 16'hABCD, 4'h0, 0, 0, 4'hE, 7'h21, 1, 0, 0);
    add(172, 16'hABCD, 4'h0, 0, 0, 4'hD, 7'h46, 1, 0, 0);
    add(182, 16'hABCD, 4'h0, 0, 0, 4'hB, 7'h03, 1, 0, 0);
    add(192, 16'hABCD, 4'h0, 0, 0, 4'h7, 7'h08, 1, 0, 0);
    add(200, 16'hABCD, 4'h0, 0, 0, 4'hF, 7'h7F, 1, 0, 1);
    // Load exactly on the wrap-tick clock (cycle 239).
    add(240, 16'h00F0, 4'h0, 1, 0, 4'hF, 7'h7F, 1, 1, 1);
    add(242, 16'h00F0, 4'h0, 0, 0, 4'hE, 7'h40, 1, 0, 0);
    add(252, 16'h00F0, 4'h0, 0, 0, 4'hD, 7'h0E, 1, 0, 0);
    add(262, 16'h00F0, 4'h0, 0, 0, 4'hB, 7'h40, 1, 0, 0);
    add(272, 16'h00F0, 4'h0, 0, 0, 4'h7, 7'h40, 1, 0, 0);
    // Leading-zero suppression, lz_en taking effect live on 0x00F0 first.
    add(291, 16'h0070, 4'h8, 1, 1, 4'hF, 7'h7F, 1, 0, 0);
    add(292, 16'h0070, 4'h8, 0, 1, 4'hD, 7'h0E, 1, 0, 0);
    add(302, 16'h0070, 4'h8, 0, 1, 4'hB, 7'h7F, 1, 0, 0);
    add(320, 16'h0070, 4'h8, 0, 1, 4'hF, 7'h7F, 1, 1, 1);
    add(322, 16'h0070, 4'h8, 0, 1, 4'hE, 7'h40, 1, 0, 0);
    add(332, 16'h0070, 4'h8, 0, 1, 4'hD, 7'h78, 1, 0, 0);
    add(342, 16'h0070, 4'h8, 0, 1, 4'hB, 7'h7F, 1, 0, 0);
    add(352, 16'h0070, 4'h8, 0, 1, 4'h7, 7'h7F, 0, 0, 0);
    // Leave a load pending for the reset sequence below.
    add(366, 16'h5555, 4'h0, 1, 1, 4'hE, 7'h40, 1, 0, 0);

    // Reset block.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk_pins("reset", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);

    // Table.
    foreach (vecs[k]) begin
      while (cyc < vecs[k].at - 1) begin
        load = 1'b0;
        step();
      end
      value_in = vecs[k].val;
      dp_in    = vecs[k].dpv;
      lz_en    = vecs[k].lz;
      load     = vecs[k].ld;
      step();
      load     = 1'b0;
      chk_pins($sformatf("vec%0d", k), vecs[k].e_an, vecs[k].e_seg,
               vecs[k].e_dp, vecs[k].e_ack, vecs[k].e_fs);
    end

    // Reset during DRIVE of digit 2 with 0x5555 still pending.
    while (cyc < 385) step();
    chk_pins("pre_rst", 4'hB, 7'h7F, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_pins("in_rst", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
    rst   = 1'b0;
    lz_en = 1'b0;
    cyc   = 0;
    while (cyc < 12) step();
    chk_pins("post_rst_d1", 4'hD, 7'h40, 1'b1, 1'b0, 1'b0);
    while (cyc < 40) step();
    chk_pins("post_rst_wrap", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
    while (cyc < 42) step();
    chk_pins("post_rst_d0", 4'hE, 7'h40, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
